// File: rtl/nibble_serial_add_sched.sv
// ============================================================================
// Module : nibble_serial_add_sched
// Shares one 4-bit CLA among N_REQ requesters, one nibble per cycle, LSB first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module carry_lookahead_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module nibble_serial_add_sched #(
    parameter int N_REQ = 2,
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    input  logic [N_REQ-1:0]           req_cin,
    input  logic [N_REQ-1:0]           req_sub,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [WIDTH-1:0]           rsp_sum,
    output logic                       rsp_cout,
    output logic                       rsp_ovf
);
    localparam int NIB = WIDTH / 4;
    localparam int IDW = $clog2(N_REQ);
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4 != 0) || (WIDTH < 4) || (N_REQ < 2) || (N_REQ > 8)) begin : g_param_check
        $error("nibble_serial_add_sched: unsupported N_REQ/WIDTH");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   rr_q;
    logic [IDW-1:0]   id_q;
    logic [KW-1:0]    k_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;

    logic             grant_any;
    logic [IDW-1:0]   grant_idx;
    logic             accept;
    logic             last_nib;
    logic [3:0]       cla_sum;
    logic             cla_cout;

    // Round-robin search: walk offsets downward so the nearest valid to rr wins.
    always_comb begin
        int idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            idx = (int'(rr_q) + j) % N_REQ;
            if (req_valid[idx]) begin
                grant_any = 1'b1;
                grant_idx = IDW'(idx);
            end
        end
    end

    assign last_nib = (k_q == KW'(NIB - 1));
    assign accept   = (state_q == S_IDLE) && grant_any;

    carry_lookahead_adder_4bit u_cla (
        .a    (a_q[int'(k_q)*4 +: 4]),
        .b    (b_q[int'(k_q)*4 +: 4]),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = 1'b0;
        rsp_sum   = '0;
        rsp_cout  = 1'b0;
        rsp_ovf   = 1'b0;
        rsp_id    = '0;
        case (state_q)
            S_IDLE: begin
                if (grant_any) begin
                    req_ready[grant_idx] = 1'b1;
                    state_d              = S_RUN;
                end
            end
            S_RUN: begin
                if (last_nib) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_sum   = sum_q;
                rsp_cout  = carry_q;
                rsp_id    = id_q;
                rsp_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The only inter-nibble carry path is carry_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q    <= '0;
            id_q    <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
        end else if (accept) begin
            a_q     <= req_a[int'(grant_idx)*WIDTH +: WIDTH];
            b_q     <= req_b[int'(grant_idx)*WIDTH +: WIDTH] ^ {WIDTH{req_sub[grant_idx]}};
            carry_q <= req_sub[grant_idx] | req_cin[grant_idx];
            id_q    <= grant_idx;
            k_q     <= '0;
            rr_q    <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
        end else if (state_q == S_RUN) begin
            sum_q[int'(k_q)*4 +: 4] <= cla_sum;
            carry_q                 <= cla_cout;
            if (!last_nib) begin
                k_q <= k_q + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add_sched.sv
// Bench for nibble_serial_add_sched (N_REQ=2, WIDTH=16): vector table plus
// scoreboard of accepted requests against an arithmetic reference model.
`default_nettype none

module tb_nibble_serial_add_sched;
    localparam int N_REQ = 2;
    localparam int WIDTH = 16;

    typedef struct {
        int          id;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_cin;
    logic [N_REQ-1:0]       req_sub;
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [0:0]             rsp_id;
    logic [WIDTH-1:0]       rsp_sum;
    logic                   rsp_cout;
    logic                   rsp_ovf;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sb_q[$];
    int   grant_q[$];
    logic [N_REQ-1:0] prev_ready = '0;

    always #5 clk = ~clk;

    nibble_serial_add_sched #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input int id, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        exp_t        e;
        logic [15:0] bb;
        logic [16:0] full;
        bb     = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, bb} + {16'd0, (sub | cin)};
        e.id   = id;
        e.sum  = full[15:0];
        e.cout = full[16];
        e.ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
        return e;
    endfunction

    // Monitor samples 2 time units after the falling edge, after the driver has settled.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (req_ready != '0) begin
                chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
                chk("ready_pulse", 32'(req_ready & prev_ready), 32'd0);
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb_q.push_back(model(i, req_a[i*WIDTH +: WIDTH], req_b[i*WIDTH +: WIDTH],
                                         req_cin[i], req_sub[i]));
                    grant_q.push_back(i);
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_id",   32'(rsp_id),   32'(e.id));
                    chk("sb_sum",  32'(rsp_sum),  32'(e.sum));
                    chk("sb_cout", 32'(rsp_cout), 32'(e.cout));
                    chk("sb_ovf",  32'(rsp_ovf),  32'(e.ovf));
                end
            end
            prev_ready = req_ready;
        end else begin
            prev_ready = '0;
        end
    end

    task automatic drive(input int id, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
        req_a[id*WIDTH +: WIDTH] = a;
        req_b[id*WIDTH +: WIDTH] = b;
        req_cin[id]              = cin;
        req_sub[id]              = sub;
        req_valid[id]            = 1'b1;
    endtask

    // Leaves the caller at negedge+1 of the first RUN cycle.
    task automatic accept(input int id, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic sub, output bit ok);
        int n;
        ok = 0;
        @(negedge clk);
        #1;
        drive(id, a, b, cin, sub);
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (!req_ready[id]) begin
            chk("accept_timeout", 32'd1, 32'd0);
            req_valid[id] = 1'b0;
            return;
        end
        ok = 1;
        @(negedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        int lat;
        accept(v.id, v.a, v.b, v.cin, v.sub, ok);
        if (!ok) return;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk("latency",  32'(lat),      32'd5);
        chk("vec_sum",  32'(rsp_sum),  32'(v.sum));
        chk("vec_cout", 32'(rsp_cout), 32'(v.cout));
        chk("vec_ovf",  32'(rsp_ovf),  32'(v.ovf));
        chk("vec_id",   32'(rsp_id),   32'(v.id));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[9];
        int   n;
        bit   ok;
        logic [15:0] s_sum;
        logic        s_cout, s_ovf;
        logic [0:0]  s_id;

        vecs[0] = '{0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{1, 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{1, 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[3] = '{0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{0, 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[5] = '{1, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[6] = '{0, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[7] = '{1, 16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[8] = '{0, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};

        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_sub   = '0;
        rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_sum",   32'(rsp_sum),   32'd0);
        chk("rst_rsp_flags", 32'({rsp_cout, rsp_ovf, rsp_id}), 32'd0);

        // Fairness: both requesters valid from reset release
        drive(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        drive(1, 16'h0005, 16'h0007, 1'b0, 1'b1);
        rst = 1'b0;
        n = 0;
        while (grant_q.size() < 4 && n < 80) begin
            @(negedge clk);
            #1;
            n++;
        end
        req_valid = '0;
        chk("fair_grant_count_ok", 32'(grant_q.size() >= 4), 32'd1);
        if (grant_q.size() >= 4) begin
            chk("fair_g0", 32'(grant_q[0]), 32'd0);
            chk("fair_g1", 32'(grant_q[1]), 32'd1);
            chk("fair_g2", 32'(grant_q[2]), 32'd0);
            chk("fair_g3", 32'(grant_q[3]), 32'd1);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("fair_drain", 32'(sb_q.size()), 32'd0);
        grant_q.delete();

        // Table-driven vectors
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: hold rsp_ready low 3 cycles with another requester waiting
        @(negedge clk);
        #1;
        rsp_ready = 1'b0;
        accept(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, ok);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bp_valid_rise", 32'(rsp_valid), 32'd1);
        chk("bp_sum", 32'(rsp_sum), 32'h0100);
        s_sum  = rsp_sum;
        s_cout = rsp_cout;
        s_ovf  = rsp_ovf;
        s_id   = rsp_id;
        drive(1, 16'h0001, 16'h0001, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_outs", 32'({rsp_sum, rsp_cout, rsp_ovf, rsp_id}),
                32'({s_sum, s_cout, s_ovf, s_id}));
            chk("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        #1;
        chk("bp_released", 32'(rsp_valid), 32'd0);

        // Reset during RUN at k = 2
        accept(0, 16'h1234, 16'h1111, 1'b0, 1'b0, ok);
        @(negedge clk);
        #1;
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", 32'({rsp_valid, rsp_sum, rsp_cout, rsp_ovf, rsp_id}), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        sb_q.delete();
        @(negedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end
        run_vec('{1, 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0});

        @(negedge clk);
        #3;
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
